// File: rtl/game_fsm.sv
`default_nettype none
// ============================================================================
// Module   : game_fsm
// Purpose  : Game flow controller. It sequences menu, play, pause, hit-grace
//            and win/lose screens, and tracks lives, level and a saturating
//            score. Button inputs are synchronized and edge detected on chip.
// Revision : 1.0  initial release
// ============================================================================
module game_fsm #(
    parameter int LIVES     = 3,
    parameter int GRACE     = 30,
    parameter int HOLD      = 120,
    parameter int MAX_LEVEL = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start_btn,
    input  logic        pause_btn,
    input  logic        collision,
    input  logic        win,
    output logic        menuScreen,
    output logic        playerWon,
    output logic        playerLost,
    output logic        run_en,
    output logic [1:0]  lives,
    output logic [2:0]  level,
    output logic [15:0] score
);

    typedef enum logic [2:0] {
        MENU  = 3'd0,
        PLAY  = 3'd1,
        PAUSE = 3'd2,
        HIT   = 3'd3,
        WON   = 3'd4,
        LOST  = 3'd5
    } state_t;

    localparam logic [1:0] c_lives     = 2'(LIVES);
    localparam logic [7:0] c_grace     = 8'(GRACE);
    localparam logic [7:0] c_hold      = 8'(HOLD);
    localparam logic [2:0] c_max_level = 3'(MAX_LEVEL);

    // [0] and [1] are the synchronizer stages, [2] is the edge-detect history
    logic [2:0]  r_start_sync;
    logic [2:0]  r_pause_sync;
    // Walks in ones after reset; edge detection is masked until the history
    // flop holds a genuinely synchronized value, so a button held through
    // reset release is not mistaken for a press.
    logic [2:0]  r_sync_ok;
    logic        r_coll_d;

    logic        w_start_p;
    logic        w_pause_p;
    logic        w_coll_p;

    state_t      r_state;
    logic        r_resume_hit;
    logic [7:0]  r_timer;
    logic        w_timer_done;
    logic [16:0] w_score_sum;
    logic [15:0] w_score_next;

    // Synchronizers, edge-detect history and collision delay
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_sync <= 3'b000;
            r_pause_sync <= 3'b000;
            r_sync_ok    <= 3'b000;
            r_coll_d     <= 1'b0;
        end else begin
            r_start_sync <= {r_start_sync[1:0], start_btn};
            r_pause_sync <= {r_pause_sync[1:0], pause_btn};
            r_sync_ok    <= {r_sync_ok[1:0], 1'b1};
            r_coll_d     <= collision;
        end
    end

    assign w_start_p = r_start_sync[1] & ~r_start_sync[2] & r_sync_ok[2];
    assign w_pause_p = r_pause_sync[1] & ~r_pause_sync[2] & r_sync_ok[2];
    assign w_coll_p  = collision & ~r_coll_d;

    // The expiring tick is the one that would take the timer from 1 to 0
    assign w_timer_done = (r_timer <= 8'd1);
    assign w_score_sum  = {1'b0, score} + {14'd0, level};
    assign w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

    // Moves to a new state and loads the matching registered screen flags
    task automatic enter(input state_t s);
        r_state    <= s;
        menuScreen <= (s == MENU);
        playerWon  <= (s == WON);
        playerLost <= (s == LOST);
        run_en     <= (s == PLAY) || (s == HIT);
    endtask

    // Game state machine with lives, level, score and the shared timer.
    // Events take precedence over a coincident tick, which is then dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= MENU;
            menuScreen   <= 1'b1;
            playerWon    <= 1'b0;
            playerLost   <= 1'b0;
            run_en       <= 1'b0;
            lives        <= c_lives;
            level        <= 3'd1;
            score        <= 16'd0;
            r_timer      <= 8'd0;
            r_resume_hit <= 1'b0;
        end else begin
            case (r_state)
                MENU: begin
                    if (w_start_p) begin
                        enter(PLAY);
                        lives <= c_lives;
                        level <= 3'd1;
                        score <= 16'd0;
                    end
                end
                PLAY: begin
                    if (win) begin
                        enter(WON);
                        r_timer <= c_hold;
                    end else if (w_coll_p) begin
                        if (lives <= 2'd1) begin
                            enter(LOST);
                            lives   <= 2'd0;
                            r_timer <= c_hold;
                        end else begin
                            enter(HIT);
                            lives   <= lives - 2'd1;
                            r_timer <= c_grace;
                        end
                    end else if (w_pause_p) begin
                        enter(PAUSE);
                        r_resume_hit <= 1'b0;
                    end else if (tick) begin
                        score <= w_score_next;
                    end
                end
                HIT: begin
                    if (win) begin
                        enter(WON);
                        r_timer <= c_hold;
                    end else if (w_pause_p) begin
                        enter(PAUSE);
                        r_resume_hit <= 1'b1;
                    end else if (tick) begin
                        score <= w_score_next;
                        if (w_timer_done) begin
                            enter(PLAY);
                            r_timer <= 8'd0;
                        end else begin
                            r_timer <= r_timer - 8'd1;
                        end
                    end
                end
                PAUSE: begin
                    if (w_start_p) begin
                        enter(MENU);
                    end else if (w_pause_p) begin
                        enter(r_resume_hit ? HIT : PLAY);
                    end
                end
                WON: begin
                    if (w_start_p) begin
                        enter(MENU);
                    end else if (tick) begin
                        if (w_timer_done) begin
                            r_timer <= 8'd0;
                            if (level < c_max_level) begin
                                enter(PLAY);
                                level <= level + 3'd1;
                            end else begin
                                enter(MENU);
                            end
                        end else begin
                            r_timer <= r_timer - 8'd1;
                        end
                    end
                end
                LOST: begin
                    if (w_start_p) begin
                        enter(MENU);
                    end else if (tick) begin
                        if (w_timer_done) begin
                            enter(MENU);
                            r_timer <= 8'd0;
                        end else begin
                            r_timer <= r_timer - 8'd1;
                        end
                    end
                end
                default: begin
                    enter(MENU);
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_fsm
// Purpose  : Directed self-checking bench for game_fsm. Expected screen flags,
//            lives, level and score are queued before each stimulus step and
//            popped and compared once the DUT has responded.
// Revision : 1.0  initial release
// ============================================================================
module tb_game_fsm;

    localparam int GRACE = 30;
    localparam int HOLD  = 120;

    localparam int S_MENU  = 0;
    localparam int S_PLAY  = 1;
    localparam int S_PAUSE = 2;
    localparam int S_HIT   = 3;
    localparam int S_WON   = 4;
    localparam int S_LOST  = 5;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        tick      = 1'b0;
    logic        start_btn = 1'b0;
    logic        pause_btn = 1'b0;
    logic        collision = 1'b0;
    logic        win       = 1'b0;
    logic        menuScreen;
    logic        playerWon;
    logic        playerLost;
    logic        run_en;
    logic [1:0]  lives;
    logic [2:0]  level;
    logic [15:0] score;

    game_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start_btn  (start_btn),
        .pause_btn  (pause_btn),
        .collision  (collision),
        .win        (win),
        .menuScreen (menuScreen),
        .playerWon  (playerWon),
        .playerLost (playerLost),
        .run_en     (run_en),
        .lives      (lives),
        .level      (level),
        .score      (score)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [24:0] exp_q[$];
    string       tag_q[$];
    int          e_lives = 3;
    int          e_level = 1;
    int          e_score = 0;

    // One clock: returns 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected observable state
    task automatic expect_st(input string tag, input int st);
        logic [24:0] v;
        v = {(st == S_MENU), (st == S_WON), (st == S_LOST),
             ((st == S_PLAY) || (st == S_HIT)),
             2'(e_lives), 3'(e_level), 16'(e_score)};
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    // Pop every queued expectation and compare against the DUT outputs
    task automatic compare_all();
        logic [24:0] obs;
        logic [24:0] e;
        string       t;
        obs = {menuScreen, playerWon, playerLost, run_en, lives, level, score};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%h expected=%h (menu,won,lost,run,lives,level,score)", t, obs, e);
            end
        end
    endtask

    // Reference score: add the level per scoring tick, saturating
    task automatic add_score(input int n);
        for (int i = 0; i < n; i++) begin
            e_score += e_level;
            if (e_score > 65535) e_score = 65535;
        end
    endtask

    task automatic ticks(input int n);
        if (n > 0) begin
            tick = 1'b1;
            repeat (n) cyc();
            tick = 1'b0;
        end
    endtask

    // Raise buttons; the FSM reacts on the third clock edge
    task automatic press(input logic s, input logic p);
        start_btn = s;
        pause_btn = p;
        repeat (3) cyc();
    endtask

    task automatic release_btns();
        start_btn = 1'b0;
        pause_btn = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic coll_edge();
        collision = 1'b1;
        cyc();
        collision = 1'b0;
        cyc();
    endtask

    task automatic win_pulse();
        win = 1'b1;
        cyc();
        win = 1'b0;
    endtask

    initial begin
        // Reset with start held high throughout
        start_btn = 1'b1;
        expect_st("rst", S_MENU);
        repeat (2) cyc();
        compare_all();
        reset = 1'b0;
        expect_st("held_btn", S_MENU);
        repeat (6) cyc();
        compare_all();
        start_btn = 1'b0;
        repeat (3) cyc();

        // Start latency: PLAY on the third edge after the raw rise
        start_btn = 1'b1;
        expect_st("menu_2clk", S_MENU);
        repeat (2) cyc();
        compare_all();
        expect_st("start_play", S_PLAY);
        cyc();
        compare_all();
        release_btns();

        add_score(5);
        expect_st("score5", S_PLAY);
        ticks(5);
        compare_all();

        // Lives drain: hit, grace, hit, then fatal hit
        e_lives = 2;
        expect_st("hit1", S_HIT);
        coll_edge();
        compare_all();
        add_score(5);
        ticks(5);
        expect_st("grace_coll", S_HIT);
        coll_edge();
        compare_all();
        add_score(GRACE - 5 + 1);
        expect_st("play_after_grace", S_PLAY);
        ticks(GRACE - 5 + 1);
        compare_all();
        e_lives = 1;
        expect_st("hit2", S_HIT);
        coll_edge();
        compare_all();
        add_score(GRACE + 1);
        expect_st("play2", S_PLAY);
        ticks(GRACE + 1);
        compare_all();
        e_lives = 0;
        expect_st("lost", S_LOST);
        coll_edge();
        compare_all();
        expect_st("lost_hold", S_LOST);
        ticks(HOLD - 1);
        compare_all();
        expect_st("lost_menu", S_MENU);
        ticks(1);
        compare_all();

        // Win beats a coincident collision; level advance up to the last
        e_lives = 3; e_level = 1; e_score = 0;
        expect_st("start2", S_PLAY);
        press(1'b1, 1'b0);
        compare_all();
        release_btns();
        collision = 1'b1;
        win       = 1'b1;
        expect_st("win_coll", S_WON);
        cyc();
        compare_all();
        collision = 1'b0;
        win       = 1'b0;
        cyc();
        expect_st("won_hold", S_WON);
        ticks(HOLD - 1);
        compare_all();
        e_level = 2;
        expect_st("won_next", S_PLAY);
        ticks(1);
        compare_all();
        win_pulse();
        e_level = 3;
        expect_st("level3", S_PLAY);
        ticks(HOLD);
        compare_all();
        win_pulse();
        e_level = 4;
        expect_st("level4", S_PLAY);
        ticks(HOLD);
        compare_all();

        // Score saturation at level 4
        add_score(16380);
        expect_st("score_fff0", S_PLAY);
        ticks(16380);
        compare_all();
        add_score(10);
        expect_st("score_sat", S_PLAY);
        ticks(10);
        compare_all();
        expect_st("won4", S_WON);
        win_pulse();
        compare_all();
        expect_st("max_menu", S_MENU);
        ticks(HOLD);
        compare_all();

        // Pause during grace freezes the timer and the score
        e_lives = 3; e_level = 1; e_score = 0;
        expect_st("start3", S_PLAY);
        press(1'b1, 1'b0);
        compare_all();
        release_btns();
        e_lives = 2;
        expect_st("hit3", S_HIT);
        coll_edge();
        compare_all();
        add_score(20);
        ticks(20);
        expect_st("pause", S_PAUSE);
        press(1'b0, 1'b1);
        compare_all();
        release_btns();
        expect_st("pause_hold", S_PAUSE);
        ticks(50);
        compare_all();
        expect_st("pause_ignore", S_PAUSE);
        coll_edge();
        win_pulse();
        compare_all();
        expect_st("resume_hit", S_HIT);
        press(1'b0, 1'b1);
        compare_all();
        release_btns();
        add_score(9);
        expect_st("hit_t9", S_HIT);
        ticks(9);
        compare_all();
        add_score(1);
        expect_st("hit_t10", S_PLAY);
        ticks(1);
        compare_all();

        // Asynchronous reset takes effect between clock edges
        e_lives = 3; e_level = 1; e_score = 0;
        expect_st("async_rst", S_MENU);
        #2;
        reset = 1'b1;
        #1;
        compare_all();
        #1;
        reset = 1'b0;
        repeat (4) cyc();

        // Start and pause together while paused returns to the menu
        expect_st("start4", S_PLAY);
        press(1'b1, 1'b0);
        compare_all();
        release_btns();
        expect_st("pause2", S_PAUSE);
        press(1'b0, 1'b1);
        compare_all();
        release_btns();
        expect_st("pause_both", S_MENU);
        press(1'b1, 1'b1);
        compare_all();
        release_btns();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_fsm.md
GAME_FSM -- requirements
Module: game_fsm

Interface
REQ-001 Parameter LIVES, default 3, starting lives per game (1..3).
REQ-002 Parameter GRACE, default 30, ticks of collision immunity after a non-fatal hit.
REQ-003 Parameter HOLD, default 120, ticks the win/lose screen is held.
REQ-004 Parameter MAX_LEVEL, default 4, last level (1..7).
REQ-005 clk  in  1  system clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 tick  in  1  one-cycle frame strobe; all timers and score advance only on tick.
REQ-008 start_btn  in  1  raw asynchronous button level.
REQ-009 pause_btn  in  1  raw asynchronous button level.
REQ-010 collision  in  1  synchronous player/obstacle overlap level.
REQ-011 win  in  1  one-cycle level-complete pulse from the obstacle counter.
REQ-012 menuScreen  out  1  high in MENU.
REQ-013 playerWon  out  1  high in WON.
REQ-014 playerLost  out  1  high in LOST.
REQ-015 run_en  out  1  obstacle counter clock enable, high in PLAY and HIT only.
REQ-016 lives  out  2  remaining lives.
REQ-017 level  out  3  current level, 1..MAX_LEVEL.
REQ-018 score  out  16  game score.

Function
REQ-019 start_btn and pause_btn SHALL each pass through a 2-flop synchronizer, then rising-edge detection producing a one-clk pulse (start_p, pause_p); latency from the raw edge to the pulse is 3 clk.
REQ-020 collision SHALL be rising-edge detected (coll_p), 1 clk latency.
REQ-021 States: MENU, PLAY, PAUSE, HIT, WON, LOST, one-hot or encoded; all outputs registered, derived from the current state.
REQ-022 MENU: start_p -> PLAY; lives<=LIVES, level<=1, score<=0.
REQ-023 PLAY: priority win > coll_p > pause_p. win -> WON; coll_p with lives==1 -> LOST with lives<=0; coll_p with lives>1 -> HIT with lives<=lives-1 and grace timer<=GRACE; pause_p -> PAUSE.
REQ-024 HIT: coll_p ignored; timer decrements on tick; timer reaching 0 -> PLAY; win -> WON (overrides timer); pause_p -> PAUSE with timer frozen, resuming in HIT.
REQ-025 PAUSE: run_en=0; win and collision ignored; pause_p -> return to the paused-from state (PLAY or HIT); start_p -> MENU; simultaneous start_p and pause_p -> MENU.
REQ-026 WON: hold timer<=HOLD on entry; decrements on tick; at 0 -> PLAY with level<=level+1 if level<MAX_LEVEL, else MENU; start_p -> MENU immediately.
REQ-027 LOST: hold timer<=HOLD on entry; at 0 or start_p -> MENU.
REQ-028 Score SHALL add level on each tick in PLAY or HIT and saturate at 16'hFFFF; it is held in all other states and cleared only on MENU->PLAY.
REQ-029 The timer SHALL be 8 bits wide and shared by HIT, WON and LOST; it is reloaded on every state entry that uses it.
REQ-030 A tick and an event in the same cycle: the state transition wins, and the tick's timer decrement and score add are not applied in the new state's cycle.

Reset
REQ-031 On reset, regardless of state: state=MENU, menuScreen=1, playerWon=0, playerLost=0, run_en=0, lives=LIVES, level=1, score=0, timer=0, synchronizer and edge-detect flops=0.
REQ-032 A button held high through reset deassertion SHALL NOT produce a pulse.
REQ-033 Reset asserted mid-game SHALL take effect immediately, not at the next clk edge.

Verification
REQ-034 Reset, then start_btn rises -> PLAY 3 clk later; run_en=1, menuScreen=0, lives=3, level=1, score=0.
REQ-035 In PLAY, three collision edges separated by GRACE+1 ticks -> lives 2, then 1, then LOST with lives=0 and playerLost=1; after 120 ticks -> MENU.
REQ-036 A collision edge 5 ticks after a hit (inside GRACE) -> lives unchanged, state HIT.
REQ-037 win and coll_p in the same cycle in PLAY -> WON with lives unchanged; after 120 ticks -> PLAY with level=2; win at level 4 -> MENU after the hold.
REQ-038 pause_p in HIT with timer=10, then 50 ticks, then pause_p -> HIT resumes with timer=10 and score unchanged across the pause.
REQ-039 Score forced near 16'hFFF0 at level 4, then 10 ticks in PLAY -> score=16'hFFFF.
